// File: rtl/ota_offset_cal.sv
// Successive-approximation offset-trim controller for a closed-loop OTA model.
// Drives a real-valued trim voltage and searches for the largest code with vout <= vref.
module ota_offset_cal #(
  parameter int  NBIT     = 6,
  parameter real LSB      = 1e-3,
  parameter int  N_SETTLE = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  real             vout,
  input  real             vref,
  output real             vos_trim,
  output logic [NBIT-1:0] code,
  output logic            busy,
  output logic            done,
  output logic            sat
);

  localparam int IW = (NBIT > 1) ? $clog2(NBIT) : 1;
  localparam int CW = (N_SETTLE > 1) ? $clog2(N_SETTLE) : 1;
  localparam logic [NBIT-1:0] MID     = NBIT'(1) << (NBIT - 1);
  localparam logic [IW-1:0]   IDX_TOP = IW'(NBIT - 1);
  localparam logic [CW-1:0]   CNT_TOP = CW'(N_SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t          r_state, w_state_n;
  logic [NBIT-1:0] r_code,  w_code_n, w_code_dec;
  logic [IW-1:0]   r_idx,   w_idx_n;
  logic [CW-1:0]   r_cnt,   w_cnt_n;
  logic            r_busy,  w_busy_n;
  logic            r_done,  w_done_n;
  logic            r_sat,   w_sat_n;
  logic            w_hi;

  // Strict comparison: a tie keeps the trial bit set.
  assign w_hi = (vout > vref);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_code  <= MID;
      r_idx   <= IDX_TOP;
      r_cnt   <= CNT_TOP;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sat   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_code  <= w_code_n;
      r_idx   <= w_idx_n;
      r_cnt   <= w_cnt_n;
      r_busy  <= w_busy_n;
      r_done  <= w_done_n;
      r_sat   <= w_sat_n;
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_code_n   = r_code;
    w_idx_n    = r_idx;
    w_cnt_n    = r_cnt;
    w_busy_n   = r_busy;
    w_done_n   = r_done;
    w_sat_n    = r_sat;
    w_code_dec = r_code;
    if (w_hi) w_code_dec[r_idx] = 1'b0;

    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_code_n  = MID;
          w_idx_n   = IDX_TOP;
          w_cnt_n   = CNT_TOP;
          w_busy_n  = 1'b1;
          w_done_n  = 1'b0;
          w_sat_n   = 1'b0;
          w_state_n = SETTLE;
        end
      end
      SETTLE: begin
        if (r_cnt == '0) w_state_n = COMPARE;
        else             w_cnt_n   = r_cnt - 1'b1;
      end
      COMPARE: begin
        w_code_n = w_code_dec;
        if (r_idx == '0) begin
          w_busy_n  = 1'b0;
          w_done_n  = 1'b1;
          w_sat_n   = (w_code_dec == '0) || (&w_code_dec);
          w_state_n = DONE;
        end else begin
          // Next trial bit goes in at this edge so the OTA sees a full settle window.
          w_idx_n                 = r_idx - 1'b1;
          w_code_n[r_idx - 1'b1]  = 1'b1;
          w_cnt_n                 = CNT_TOP;
          w_state_n               = SETTLE;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  assign code     = r_code;
  assign busy     = r_busy;
  assign done     = r_done;
  assign sat      = r_sat;
  assign vos_trim = real'(int'(r_code) - int'(MID)) * LSB;

endmodule

// File: tb/tb_ota_offset_cal.sv
// Directed bench: closed-loop OTA model vout = vref + 10*(vos_true + vos_trim).
module tb_ota_offset_cal;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  real        vout;
  real        vref = 0.6;
  real        vos_trim;
  logic [5:0] code;
  logic       busy, done, sat;
  real        vos_true = 0.0;

  int n_cmp = 0;
  int n_err = 0;

  assign vout = vref + 10.0 * (vos_true + vos_trim);

  always #5 clk = ~clk;

  ota_offset_cal #(.NBIT(6), .LSB(1e-3), .N_SETTLE(8)) dut (
    .clk(clk), .rst(rst), .start(start), .vout(vout), .vref(vref),
    .vos_trim(vos_trim), .code(code), .busy(busy), .done(done), .sat(sat)
  );

  // Pulse start, then count edges until done (bounded). pulse_at>0 re-pulses start mid-run.
  task automatic do_cal(input real vt, input int pulse_at,
                        output int lat, output int bcyc, output logic d0, output logic b0);
    vos_true = vt;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    d0 = done; b0 = busy;
    lat = 0; bcyc = 0;
    while (lat < 200) begin
      if (lat + 1 == pulse_at) start = 1'b1;
      @(posedge clk);
      @(negedge clk) start = 1'b0;
      lat++;
      if (busy) bcyc++;
      if (busy && done) begin
        n_cmp++; n_err++;
        $display("FAIL busy_done_overlap at cycle %0d", lat);
      end
      if (done) break;
    end
  endtask

  task automatic test_reset();
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    n_cmp++; if (code !== 6'd32) begin n_err++; $display("FAIL reset_code got %0d want 32", code); end
    n_cmp++; if (vos_trim != 0.0) begin n_err++; $display("FAIL reset_trim got %f want 0", vos_trim); end
    n_cmp++; if ({busy, done, sat} !== 3'b000) begin n_err++; $display("FAIL reset_flags got %b want 000", {busy, done, sat}); end
  endtask

  task automatic test_mid();
    int lat, bc; logic d0, b0;
    do_cal(-5.3e-3, 0, lat, bc, d0, b0);
    n_cmp++; if (b0 !== 1'b1) begin n_err++; $display("FAIL mid_busy_start got %b want 1", b0); end
    n_cmp++; if (lat != 54) begin n_err++; $display("FAIL mid_latency got %0d want 54", lat); end
    n_cmp++; if (bc != 53) begin n_err++; $display("FAIL mid_busy_cycles got %0d want 53", bc); end
    n_cmp++; if (code !== 6'd37) begin n_err++; $display("FAIL mid_code got %0d want 37", code); end
    n_cmp++; if ((vos_trim - 5e-3) > 1e-9 || (vos_trim - 5e-3) < -1e-9) begin n_err++; $display("FAIL mid_trim got %f want 0.005", vos_trim); end
    n_cmp++; if ({busy, done, sat} !== 3'b010) begin n_err++; $display("FAIL mid_flags got %b want 010", {busy, done, sat}); end
  endtask

  task automatic test_sat_low();
    int lat, bc; logic d0, b0;
    do_cal(40e-3, 0, lat, bc, d0, b0);
    n_cmp++; if (code !== 6'd0) begin n_err++; $display("FAIL satlo_code got %0d want 0", code); end
    n_cmp++; if ((vos_trim + 32e-3) > 1e-9 || (vos_trim + 32e-3) < -1e-9) begin n_err++; $display("FAIL satlo_trim got %f want -0.032", vos_trim); end
    n_cmp++; if ({done, sat} !== 2'b11) begin n_err++; $display("FAIL satlo_flags got %b want 11", {done, sat}); end
  endtask

  task automatic test_sat_high();
    int lat, bc; logic d0, b0;
    do_cal(-50e-3, 0, lat, bc, d0, b0);
    n_cmp++; if (code !== 6'd63) begin n_err++; $display("FAIL sathi_code got %0d want 63", code); end
    n_cmp++; if ((vos_trim - 31e-3) > 1e-9 || (vos_trim - 31e-3) < -1e-9) begin n_err++; $display("FAIL sathi_trim got %f want 0.031", vos_trim); end
    n_cmp++; if ({done, sat} !== 2'b11) begin n_err++; $display("FAIL sathi_flags got %b want 11", {done, sat}); end
  endtask

  task automatic test_tie();
    int lat, bc; logic d0, b0;
    do_cal(0.0, 0, lat, bc, d0, b0);
    n_cmp++; if (code !== 6'd32) begin n_err++; $display("FAIL tie_code got %0d want 32", code); end
    n_cmp++; if (vos_trim != 0.0) begin n_err++; $display("FAIL tie_trim got %f want 0", vos_trim); end
    n_cmp++; if ({done, sat} !== 2'b10) begin n_err++; $display("FAIL tie_flags got %b want 10", {done, sat}); end
  endtask

  task automatic test_restart_from_done();
    int lat, bc; logic d0, b0;
    do_cal(-5.3e-3, 0, lat, bc, d0, b0);
    n_cmp++; if (code !== 6'd37) begin n_err++; $display("FAIL rs_pre_code got %0d want 37", code); end
    do_cal(7.6e-3, 0, lat, bc, d0, b0);
    n_cmp++; if (d0 !== 1'b0) begin n_err++; $display("FAIL rs_done_drop got %b want 0", d0); end
    n_cmp++; if (lat != 54) begin n_err++; $display("FAIL rs_latency got %0d want 54", lat); end
    n_cmp++; if (code !== 6'd24) begin n_err++; $display("FAIL rs_code got %0d want 24", code); end
    n_cmp++; if ((vos_trim + 8e-3) > 1e-9 || (vos_trim + 8e-3) < -1e-9) begin n_err++; $display("FAIL rs_trim got %f want -0.008", vos_trim); end
  endtask

  task automatic test_rst_abort();
    vos_true = -5.3e-3;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    n_cmp++; if (code !== 6'd32) begin n_err++; $display("FAIL abort_code got %0d want 32", code); end
    n_cmp++; if (vos_trim != 0.0) begin n_err++; $display("FAIL abort_trim got %f want 0", vos_trim); end
    n_cmp++; if ({busy, done, sat} !== 3'b000) begin n_err++; $display("FAIL abort_flags got %b want 000", {busy, done, sat}); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_stays_idle got %b want 0", busy); end
  endtask

  task automatic test_start_during_busy();
    int lat, bc; logic d0, b0;
    do_cal(-5.3e-3, 10, lat, bc, d0, b0);
    n_cmp++; if (lat != 54) begin n_err++; $display("FAIL sdb_latency got %0d want 54", lat); end
    n_cmp++; if (code !== 6'd37) begin n_err++; $display("FAIL sdb_code got %0d want 37", code); end
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_cmp++; if ({busy, done} !== 2'b01) begin n_err++; $display("FAIL sdb_hold got %b want 01", {busy, done}); end
  endtask

  initial begin
    test_reset();
    test_mid();
    test_sat_low();
    test_sat_high();
    test_tie();
    test_restart_from_done();
    test_rst_abort();
    test_start_during_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ota_offset_cal.md
# ota_offset_cal

Clocked successive-approximation offset-trim controller for a closed-loop linear OTA model. It samples the OTA's PWL output against a reference and drives the OTA's real-valued `vos` input with a trim voltage. After calibration the amplifier output sits at the reference to within one trim LSB. It sits in the OTA's feedback path: it consumes the OTA output and feeds the OTA offset input.

## Interface
Parameters:
- `NBIT`, 6: trim code width.
- `LSB`, 1e-3: trim step in volts per code.
- `N_SETTLE`, 8: clock cycles allowed for OTA settling before each comparison (≥1).

Ports (`clk` and `rst` first):
- `clk`  input  1  sole clock; all state changes on rising edge.
- `rst`  input  1  synchronous, active-high reset, sampled on the `clk` rising edge.
- `start`  input  1  calibration request, sampled on the `clk` rising edge.
- `vout`  input  pwl  OTA output (`input_pwl`).
- `vref`  input  real  target output voltage (`input_real`).
- `vos_trim`  output  real  trim voltage driven to the OTA `vos` input (`output_real`).
- `code`  output  NBIT  current trim code.
- `busy`  output  1  high while calibration runs.
- `done`  output  1  high when a calibration result is valid.
- `sat`  output  1  high when the final code is all-zeros or all-ones.

## Operation
- Trim mapping is continuous: `vos_trim = (code − 2^(NBIT−1)) × LSB`, updated whenever `code` changes.
- Reset values: `code = 2^(NBIT−1)` (so `vos_trim = 0.0`), `busy = 0`, `done = 0`, `sat = 0`, state `IDLE`.
- States:
  - `IDLE`: waits for `start`.
  - `SETTLE`: counts down the settling delay.
  - `COMPARE`: makes one bit decision.
  - `DONE`: holds the result.
- `IDLE` or `DONE` with `start=1`:
  - Set `code = 2^(NBIT−1)` (trial MSB set).
  - Set bit index `idx = NBIT−1` and `cnt = N_SETTLE−1`.
  - Set `busy=1`, `done=0`, `sat=0`.
  - Go to `SETTLE`.
- `SETTLE`: if `cnt==0` go to `COMPARE`, else `cnt−−`.
- `COMPARE`:
  - Evaluate `vout` at the current simulation time with the PWL evaluation method.
  - If `vout > vref` strictly, clear `code[idx]`. A tie keeps the bit.
  - If `idx==0`: go to `DONE`, set `busy=0`, `done=1`, and `sat = (code==0 || code==all-ones)` using the post-decision code.
  - Otherwise: `idx−−`, set `code[idx−1]=1`, `cnt=N_SETTLE−1`, and go to `SETTLE`.
- `DONE`: holds `code`, `vos_trim`, `done=1` and `sat` until `rst` or a new `start`.
- Sign convention: a positive `vos_trim` raises the OTA output. The search therefore converges to the largest code for which `vout ≤ vref`.

## Timing
- Per bit: `N_SETTLE` cycles in `SETTLE` plus 1 cycle in `COMPARE`.
- With `start` sampled at edge k, `done` rises at edge k + NBIT·(N_SETTLE+1). With defaults this is k+54.
- `busy` is high from edge k+1 until the final `COMPARE` edge. `busy` and `done` are never high together.
- `start` is ignored while `busy=1`. Holding `start` high in `DONE` restarts calibration every completion.
- `rst` takes priority over `start` and over any state. Asserting `rst` mid-calibration returns all outputs to reset values at that edge and aborts the search.
- Each trial code is applied at the edge that sets it, giving the OTA the full `N_SETTLE` cycles before it is sampled.
- `vout` is sampled only at `COMPARE` edges. PWL events on `vout` at other times have no effect.

## Test plan
Defaults throughout (NBIT=6, LSB=1 mV, N_SETTLE=8). The bench models the OTA as `vout = vref + 10·(vos_true + vos_trim)`, with `vref = 0.6`.

1. `vos_true = −5.3 mV`, pulse `start` → after 54 cycles: `code=37`, `vos_trim=+5 mV`, `done=1`, `sat=0`; `busy` was high for exactly 53 cycles.
2. `vos_true = +40 mV` → `code=0`, `vos_trim=−32 mV`, `sat=1`, `done=1`.
3. `vos_true = −50 mV` → `code=63`, `vos_trim=+31 mV`, `sat=1`.
4. `vos_true = 0` exactly (tie case) → `code=32`, `vos_trim=0`, `sat=0`.
5. Assert `rst` at cycle 20 after `start` → next edge: `code=32`, `vos_trim=0`, `busy=0`, `done=0`. A `start` pulse during `busy` in a separate run does not alter the 54-cycle latency or the result.
6. From `DONE` with case 1's result, change `vos_true` to +7.6 mV and pulse `start` → `done` drops at the next edge; after 54 cycles `code=24`, `vos_trim=−8 mV`.
